// File: rtl/rtx_ctrl.sv
// rtx_ctrl: retransmit-buffer controller.
// Captures outgoing packets into an 8-entry ring of 64-beat slots in the
// external retransmit RAM, frees entries on cumulative ACK and replays all
// unacknowledged packets on NAK.
module rtx_ctrl #(
  parameter int ENTRY_W      = 3,
  parameter int SLOT_W       = 6,
  parameter int RTX_DATA_PTR = 9,
  parameter int SEQ_W        = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  // outgoing packet stream
  input  logic [255:0]            tx_data_i,
  input  logic                    tx_valid_i,
  input  logic                    tx_last_i,
  input  logic [SEQ_W-1:0]        tx_seq_i,
  output logic                    tx_ready_o,
  // retransmit RAM write port
  output logic [255:0]            ox2b_rtx_wrdata_o,
  output logic [RTX_DATA_PTR-1:0] ox2b_rtx_wrdata_wdaddr,
  output logic                    ox2b_rtx_wrdata_we_o,
  // retransmit RAM read port
  output logic [RTX_DATA_PTR-1:0] ox2b_rtx_rddata_rdaddr,
  output logic                    ox2b_rtx_rddata_re_o,
  input  logic [255:0]            b2ox_rtx_rddata_i,
  // ACK / NAK events
  input  logic                    ack_valid_i,
  input  logic [SEQ_W-1:0]        ack_seq_i,
  input  logic                    ack_nak_i,
  // replay stream
  output logic [255:0]            rpl_data_o,
  output logic                    rpl_valid_o,
  output logic                    rpl_last_o,
  output logic [SEQ_W-1:0]        rpl_seq_o,
  input  logic                    rpl_ready_i,
  // status
  output logic [ENTRY_W:0]        rtx_count_o,
  output logic                    rtx_full_o,
  output logic                    rtx_empty_o,
  output logic                    rpl_busy_o,
  output logic                    ovf_err_o
);

  localparam int unsigned NUM_ENT = 1 << ENTRY_W;
  localparam logic [ENTRY_W:0] CNT_FULL = {1'b1, {ENTRY_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FREE = 2'd1,
    ST_RD   = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   head_q, head_d;
  logic [ENTRY_W-1:0]   tail_q, tail_d;
  logic [ENTRY_W:0]     count_q, count_d;
  logic [SLOT_W-1:0]    wr_beat_q, wr_beat_d;
  logic                 wr_full_q, wr_full_d;
  logic                 ovf_q, ovf_d;
  logic                 pend_v_q, pend_v_d;
  logic                 pend_nak_q, pend_nak_d;
  logic [SEQ_W-1:0]     pend_seq_q, pend_seq_d;
  logic [ENTRY_W-1:0]   rd_ent_q, rd_ent_d;
  logic [SLOT_W-1:0]    rd_beat_q, rd_beat_d;

  // per-entry metadata: sequence number and index of the last written beat
  logic [SEQ_W-1:0]     seq_q [NUM_ENT];
  logic [SLOT_W-1:0]    len_q [NUM_ENT];

  logic                 tx_accept;
  logic                 seq_we;
  logic                 len_we;
  logic                 commit;
  logic                 free_ent;
  logic                 pend_clr;
  logic                 rpl_last_raw;
  logic [ENTRY_W-1:0]   rd_ent_inc;

  // modular sequence compare: a is at or before b
  function automatic logic seq_le(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] diff;
    diff = b - a;
    return !diff[SEQ_W-1];
  endfunction

  assign rtx_full_o   = (count_q == CNT_FULL);
  assign rtx_empty_o  = (count_q == '0);
  assign rtx_count_o  = count_q;
  assign rpl_busy_o   = (state_q == ST_RD) || (state_q == ST_SEND);
  assign ovf_err_o    = ovf_q;
  assign tx_ready_o   = !rtx_full_o && !rpl_busy_o;
  assign tx_accept    = tx_valid_i && tx_ready_o;
  assign rpl_last_raw = (rd_beat_q == len_q[rd_ent_q]);
  assign rd_ent_inc   = rd_ent_q + 1'b1;

  // RAM ports; address/data are forced to zero when the strobe is low so
  // every port reads zero out of reset regardless of RAM contents
  assign ox2b_rtx_wrdata_we_o   = tx_accept && !wr_full_q;
  assign ox2b_rtx_wrdata_wdaddr = ox2b_rtx_wrdata_we_o ? {tail_q, wr_beat_q} : '0;
  assign ox2b_rtx_wrdata_o      = ox2b_rtx_wrdata_we_o ? tx_data_i : '0;
  assign ox2b_rtx_rddata_re_o   = (state_q == ST_RD);
  assign ox2b_rtx_rddata_rdaddr = ox2b_rtx_rddata_re_o ? {rd_ent_q, rd_beat_q} : '0;

  // replay stream decode from the FSM registers
  assign rpl_valid_o = (state_q == ST_SEND);
  assign rpl_last_o  = rpl_valid_o && rpl_last_raw;
  assign rpl_seq_o   = rpl_valid_o ? seq_q[rd_ent_q] : '0;
  assign rpl_data_o  = rpl_valid_o ? b2ox_rtx_rddata_i : '0;

  // next-state logic: write path, pending event register and replay FSM
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wr_beat_d  = wr_beat_q;
    wr_full_d  = wr_full_q;
    ovf_d      = ovf_q;
    rd_ent_d   = rd_ent_q;
    rd_beat_d  = rd_beat_q;
    seq_we     = 1'b0;
    len_we     = 1'b0;
    commit     = 1'b0;
    free_ent   = 1'b0;
    pend_clr   = 1'b0;

    // write path; once 64 beats are in, wr_beat parks at 63 so the committed
    // length saturates there and further beats are dropped
    if (tx_accept) begin
      if (wr_beat_q == '0 && !wr_full_q) begin
        seq_we = 1'b1;
      end
      if (wr_full_q) begin
        ovf_d = 1'b1;
      end
      if (tx_last_i) begin
        commit    = 1'b1;
        len_we    = 1'b1;
        tail_d    = tail_q + 1'b1;
        wr_beat_d = '0;
        wr_full_d = 1'b0;
      end else if (!wr_full_q) begin
        if (wr_beat_q == '1) begin
          wr_full_d = 1'b1;
        end else begin
          wr_beat_d = wr_beat_q + 1'b1;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_v_q) begin
          state_d = ST_FREE;
        end
      end
      ST_FREE: begin
        if (count_q != '0 && seq_le(seq_q[head_q], pend_seq_q)) begin
          free_ent = 1'b1;
          head_d   = head_q + 1'b1;
        end else begin
          pend_clr = 1'b1;
          if (pend_nak_q && count_q != '0) begin
            state_d   = ST_RD;
            rd_ent_d  = head_q;
            rd_beat_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RD: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (rpl_ready_i) begin
          if (rpl_last_raw) begin
            rd_ent_d  = rd_ent_inc;
            rd_beat_d = '0;
            state_d   = (rd_ent_inc != tail_q) ? ST_RD : ST_IDLE;
          end else begin
            rd_beat_d = rd_beat_q + 1'b1;
            state_d   = ST_RD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case ({commit, free_ent})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // a new event wins over the clear issued at the end of FREE
    pend_v_d   = ack_valid_i ? 1'b1 : (pend_clr ? 1'b0 : pend_v_q);
    pend_seq_d = ack_valid_i ? ack_seq_i : pend_seq_q;
    pend_nak_d = (pend_clr ? 1'b0 : pend_nak_q) | (ack_valid_i & ack_nak_i);
  end

  // control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wr_beat_q  <= '0;
      wr_full_q  <= 1'b0;
      ovf_q      <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_nak_q <= 1'b0;
      pend_seq_q <= '0;
      rd_ent_q   <= '0;
      rd_beat_q  <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wr_beat_q  <= wr_beat_d;
      wr_full_q  <= wr_full_d;
      ovf_q      <= ovf_d;
      pend_v_q   <= pend_v_d;
      pend_nak_q <= pend_nak_d;
      pend_seq_q <= pend_seq_d;
      rd_ent_q   <= rd_ent_d;
      rd_beat_q  <= rd_beat_d;
    end
  end

  // per-entry metadata tables, not reset (only read for committed entries)
  always_ff @(posedge clk) begin
    if (seq_we) begin
      seq_q[tail_q] <= tx_seq_i;
    end
    if (len_we) begin
      len_q[tail_q] <= wr_beat_q;
    end
  end

endmodule

// File: tb/tb_rtx_ctrl.sv
// tb_rtx_ctrl: self-checking bench for rtx_ctrl with a behavioural RAM and a
// packet-queue reference model.
module tb_rtx_ctrl;
  localparam int ENTRY_W = 3;
  localparam int SLOT_W  = 6;
  localparam int PTR_W   = 9;
  localparam int SEQ_W   = 22;

  logic               clk = 1'b0;
  logic               rst;
  logic [255:0]       tx_data;
  logic               tx_valid, tx_last, tx_ready;
  logic [SEQ_W-1:0]   tx_seq;
  logic [255:0]       wrdata;
  logic [PTR_W-1:0]   wraddr, rdaddr;
  logic               we, re;
  logic [255:0]       rddata;
  logic               ack_valid, ack_nak;
  logic [SEQ_W-1:0]   ack_seq;
  logic [255:0]       rpl_data;
  logic               rpl_valid, rpl_last, rpl_ready;
  logic [SEQ_W-1:0]   rpl_seq;
  logic [ENTRY_W:0]   count;
  logic               full, empty, busy, ovf;

  rtx_ctrl #(.ENTRY_W(ENTRY_W), .SLOT_W(SLOT_W), .RTX_DATA_PTR(PTR_W), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_last_i(tx_last), .tx_seq_i(tx_seq),
    .tx_ready_o(tx_ready),
    .ox2b_rtx_wrdata_o(wrdata), .ox2b_rtx_wrdata_wdaddr(wraddr), .ox2b_rtx_wrdata_we_o(we),
    .ox2b_rtx_rddata_rdaddr(rdaddr), .ox2b_rtx_rddata_re_o(re), .b2ox_rtx_rddata_i(rddata),
    .ack_valid_i(ack_valid), .ack_seq_i(ack_seq), .ack_nak_i(ack_nak),
    .rpl_data_o(rpl_data), .rpl_valid_o(rpl_valid), .rpl_last_o(rpl_last), .rpl_seq_o(rpl_seq),
    .rpl_ready_i(rpl_ready),
    .rtx_count_o(count), .rtx_full_o(full), .rtx_empty_o(empty), .rpl_busy_o(busy),
    .ovf_err_o(ovf)
  );

  always #5 clk = ~clk;

  // retransmit RAM: registered read, output held while re is low
  logic [255:0] ram [512];
  always @(posedge clk) begin
    if (we) ram[wraddr] <= wrdata;
    if (re) rddata <= ram[rdaddr];
  end

  typedef struct {
    logic [SEQ_W-1:0] seq;
    int               len;
    int               uid;
    int               ent;
  } pkt_t;

  typedef struct {
    int               len;
    logic [SEQ_W-1:0] seq;
    int               exp_count;
    bit               exp_ready;
    bit               exp_full;
    bit               exp_empty;
  } pvec_t;

  pkt_t q_m[$];
  int   tail_m;
  int   uid_ctr;
  int   checks;
  int   errors;

  function automatic logic [255:0] data_of(input int uid, input int beat);
    logic [31:0] w;
    w = {uid[15:0], beat[15:0]} ^ 32'h5A3C_96E1;
    return {8{w}};
  endfunction

  function automatic bit seq_le_m(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] d;
    d = b - a;
    return d < 22'h200000;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, tx_ready, 1);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_zero"}, {we, re, wraddr, rdaddr, rpl_valid, rpl_last, rpl_seq, full, busy, ovf, count}, 0);
    chk({tag, "_wrdata"}, wrdata, 0);
    chk({tag, "_rpldata"}, rpl_data, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tx_valid = 1'b0; tx_last = 1'b0; ack_valid = 1'b0; ack_nak = 1'b0; rpl_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    q_m.delete();
    tail_m = 0;
    check_idle_outputs("rst");
  endtask

  task automatic send_pkt(input int len, input logic [SEQ_W-1:0] seq);
    int uid, writes, w;
    pkt_t p;
    uid = uid_ctr;
    uid_ctr++;
    writes = 0;
    for (int b = 0; b < len; b++) begin
      @(negedge clk);
      tx_valid = 1'b1; tx_data = data_of(uid, b); tx_last = (b == len - 1); tx_seq = seq;
      #1;
      w = 0;
      while (!tx_ready && w < 200) begin
        @(negedge clk); #1; w++;
      end
      if (!tx_ready) begin
        chk("tx_ready_timeout", 0, 1);
        break;
      end
      if (b < 64) begin
        chk("wr_addr", {we, wraddr}, {1'b1, 3'(tail_m), 6'(b)});
        chk("wr_data", wrdata, data_of(uid, b));
      end else begin
        chk("wr_ovf_we", we, 0);
      end
      if (we) writes++;
    end
    @(negedge clk);
    tx_valid = 1'b0; tx_last = 1'b0;
    chk("wr_count", writes, (len > 64) ? 64 : len);
    p.seq = seq; p.len = (len > 64) ? 64 : len; p.uid = uid; p.ent = tail_m;
    q_m.push_back(p);
    tail_m = (tail_m + 1) % 8;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall the first beat 5 cycles
  task automatic ack_event(input logic [SEQ_W-1:0] s, input bit nak, input int mode);
    logic [255:0]     e_data[$];
    logic [SEQ_W-1:0] e_seq[$];
    bit               e_last[$];
    logic [PTR_W-1:0] e_addr[$];
    logic [255:0]     held;
    int  got, reads, cyc, stall;
    bit  seen_busy, bad_rdy, bad_hold, held_v, done;
    @(negedge clk);
    ack_valid = 1'b1; ack_seq = s; ack_nak = nak;
    @(negedge clk);
    ack_valid = 1'b0; ack_nak = 1'b0;
    while (q_m.size() > 0 && seq_le_m(q_m[0].seq, s)) void'(q_m.pop_front());
    if (nak) begin
      foreach (q_m[i]) begin
        for (int b = 0; b < q_m[i].len; b++) begin
          e_data.push_back(data_of(q_m[i].uid, b));
          e_seq.push_back(q_m[i].seq);
          e_last.push_back(b == q_m[i].len - 1);
          e_addr.push_back({3'(q_m[i].ent), 6'(b)});
        end
      end
    end
    got = 0; reads = 0; cyc = 0; stall = 0;
    seen_busy = 0; bad_rdy = 0; bad_hold = 0; held_v = 0; done = 0; held = '0;
    while (!done && cyc < 1500) begin
      case (mode)
        0:       rpl_ready = 1'b1;
        1:       rpl_ready = 1'($urandom_range(0, 1));
        default: rpl_ready = (stall >= 5);
      endcase
      #1;
      if (busy) begin
        seen_busy = 1;
        if (tx_ready) bad_rdy = 1;
      end
      if (re) begin
        if (reads < e_addr.size()) chk("rd_addr", rdaddr, e_addr[reads]);
        else chk("rd_extra", reads, e_addr.size());
        reads++;
      end
      if (rpl_valid) begin
        if (!rpl_ready) begin
          if (held_v && rpl_data !== held) bad_hold = 1;
          held = rpl_data;
          held_v = 1;
          stall++;
        end else begin
          if (got < e_data.size()) begin
            chk("rpl_data", rpl_data, e_data[got]);
            chk("rpl_seq_last", {rpl_last, rpl_seq}, {e_last[got], e_seq[got]});
          end else begin
            chk("rpl_extra", got, e_data.size());
          end
          held_v = 0;
          got++;
        end
      end
      done = (e_data.size() == 0) ? (cyc >= 12) : (seen_busy && !busy);
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    rpl_ready = 1'b0;
    if (!done) chk("ack_timeout", 0, 1);
    chk("rpl_beats", got, e_data.size());
    chk("rd_count", reads, e_addr.size());
    chk("count", count, q_m.size());
    chk("empty_full", {empty, full}, {q_m.size() == 0, q_m.size() == 8});
    if (got > 0) chk("ready_low_in_replay", bad_rdy, 0);
    if (mode == 2) chk("rpl_hold", {bad_hold, stall >= 5}, 2'b01);
  endtask

  pvec_t pv[3];

  task automatic run_table();
    for (int i = 0; i < 3; i++) begin
      send_pkt(pv[i].len, pv[i].seq);
      #1;
      chk("tbl_count", count, pv[i].exp_count);
      chk("tbl_flags", {tx_ready, full, empty}, {pv[i].exp_ready, pv[i].exp_full, pv[i].exp_empty});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SEQ_W-1:0] nseq, s;
    int k, w;
    checks = 0; errors = 0; uid_ctr = 1; tail_m = 0;
    rst = 1'b1; tx_valid = 1'b0; tx_last = 1'b0; tx_data = '0; tx_seq = '0;
    ack_valid = 1'b0; ack_seq = '0; ack_nak = 1'b0; rpl_ready = 1'b0;

    pv[0] = '{4,  22'd10, 1, 1'b1, 1'b0, 1'b0};
    pv[1] = '{1,  22'd11, 2, 1'b1, 1'b0, 1'b0};
    pv[2] = '{64, 22'd12, 3, 1'b1, 1'b0, 1'b0};

    // capture 10/11/12, then cumulative ACK 11
    do_reset();
    run_table();
    ack_event(22'd11, 1'b0, 0);

    // NAK 10 frees entry 10 and replays 11 and 12 with a stalled first beat
    do_reset();
    run_table();
    ack_event(22'd10, 1'b1, 2);

    // fill the ring, then free the oldest entry
    do_reset();
    for (int i = 0; i < 8; i++) send_pkt(1, 22'(20 + i));
    #1;
    chk("full_flags", {full, tx_ready, count}, {1'b1, 1'b0, 4'd8});
    ack_event(22'd20, 1'b0, 0);
    chk("ready_after_free", tx_ready, 1);

    // 66-beat packet overflows; replay ends on beat 63
    do_reset();
    send_pkt(66, 22'd100);
    #1;
    chk("ovf_set", ovf, 1);
    send_pkt(1, 22'd101);
    #1;
    chk("ovf_sticky", ovf, 1);
    ack_event(22'd99, 1'b1, 0);
    chk("ovf_after_rpl", ovf, 1);

    // sequence wrap, then reset in the middle of a replay
    do_reset();
    send_pkt(1, 22'h3FFFFE);
    send_pkt(1, 22'h3FFFFF);
    send_pkt(1, 22'h000000);
    ack_event(22'h3FFFFF, 1'b0, 0);
    send_pkt(3, 22'h000001);
    @(negedge clk);
    ack_valid = 1'b1; ack_seq = 22'h3FFFFF; ack_nak = 1'b1;
    @(negedge clk);
    ack_valid = 1'b0; ack_nak = 1'b0; rpl_ready = 1'b1;
    #1;
    w = 0;
    while (!busy && w < 20) begin
      @(negedge clk); #1; w++;
    end
    chk("rpl_started", busy, 1);
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // randomized traffic against the queue model
    nseq = 22'h3FFFF0 + 22'($urandom_range(0, 12));
    for (int it = 0; it < 60; it++) begin
      if (q_m.size() < 8 && $urandom_range(0, 2) != 0) begin
        send_pkt(int'($urandom_range(1, 6)), nseq);
        nseq++;
      end else begin
        k = int'($urandom_range(0, q_m.size()));
        if (q_m.size() == 0) s = nseq - 1'b1;
        else if (k == 0) s = q_m[0].seq - 1'b1;
        else s = q_m[k-1].seq;
        ack_event(s, 1'($urandom_range(0, 1)), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
